// File: rtl/bin_seq_monitor_if.sv
// Connection bundle between an upstream binary counter stage and its sequence monitor.
// The master side drives the sampled counter signals, the slave side returns status.
interface bin_seq_monitor_if #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
);
    logic                  cnt_en;
    logic [WIDTH-1:0]      count;
    logic                  clr;
    logic                  locked;
    logic                  err_pulse;
    logic [ERR_CNT_W-1:0]  err_count;
    logic                  wrap_pulse;
    logic [WRAP_CNT_W-1:0] wrap_count;

    modport master (
        output cnt_en, count, clr,
        input  locked, err_pulse, err_count, wrap_pulse, wrap_count
    );

    modport slave (
        input  cnt_en, count, clr,
        output locked, err_pulse, err_count, wrap_pulse, wrap_count
    );
endinterface

// File: rtl/bin_seq_monitor.sv
// Checks that an enabled binary counter either increments by one or holds on every clock,
// locks after a run of good increments, and keeps saturating error and wrap statistics.
module bin_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input logic              clk,
    input logic              rstb,
    bin_seq_monitor_if.slave bus
);
    localparam int RUN_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      prev_count;
    logic                  prev_en;
    logic [RUN_W-1:0]      run;
    logic                  locked;
    logic                  err_pulse;
    logic                  wrap_pulse;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [WRAP_CNT_W-1:0] wrap_count;

    logic [WIDTH-1:0]      exp_count;
    logic                  match;
    logic                  wrap_step;
    logic [RUN_W-1:0]      run_inc;

    always_comb begin
        exp_count = prev_en ? prev_count + WIDTH'(1) : prev_count;
        match     = (bus.count == exp_count);
        wrap_step = match && prev_en && (&prev_count);
        run_inc   = run + RUN_W'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= UNSYNC;
            prev_count <= '0;
            prev_en    <= 1'b0;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else if (bus.clr) begin
            // Resync: the sample on this edge is discarded, so UNSYNC captures afresh next edge.
            state      <= UNSYNC;
            prev_count <= '0;
            prev_en    <= 1'b0;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            prev_count <= bus.count;
            prev_en    <= bus.cnt_en;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            case (state)
                UNSYNC: begin
                    state  <= ACQUIRE;
                    run    <= '0;
                    locked <= 1'b0;
                end
                ACQUIRE: begin
                    if (!match) begin
                        run <= '0;
                    end else if (prev_en) begin
                        run <= run_inc;
                        if (run_inc == LOCK_VAL) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state     <= ACQUIRE;
                        locked    <= 1'b0;
                        run       <= '0;
                        err_pulse <= 1'b1;
                        if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
                    end else if (wrap_step) begin
                        wrap_pulse <= 1'b1;
                        if (!(&wrap_count)) wrap_count <= wrap_count + WRAP_CNT_W'(1);
                    end
                end
                default: begin
                    state  <= UNSYNC;
                    run    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked     = locked;
    assign bus.err_pulse  = err_pulse;
    assign bus.wrap_pulse = wrap_pulse;
    assign bus.err_count  = err_count;
    assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_bin_seq_monitor.sv
// Self-checking bench: directed scenarios plus a randomized run, both checked against
// a behavioural model of the counter-step rules; a second instance has a 2-bit error counter.
module tb_bin_seq_monitor;
    localparam int LC = 3;

    logic clk;
    logic rstb;
    logic cnt_en_s;
    logic [3:0] count_s;
    logic clr_s;

    bin_seq_monitor_if #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8)) bus1 ();
    bin_seq_monitor_if #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) bus2 ();

    assign bus1.cnt_en = cnt_en_s;
    assign bus1.count  = count_s;
    assign bus1.clr    = clr_s;
    assign bus2.cnt_en = cnt_en_s;
    assign bus2.count  = count_s;
    assign bus2.clr    = clr_s;

    bin_seq_monitor #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(8), .WRAP_CNT_W(8)) dut1 (
        .clk(clk), .rstb(rstb), .bus(bus1.slave));
    bin_seq_monitor #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(2), .WRAP_CNT_W(8)) dut2 (
        .clk(clk), .rstb(rstb), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Upstream counter as the bench presents it.
    logic [3:0] cur_cnt;
    bit         cur_en;

    // Reference model state.
    bit         m_valid, m_locked, m_ep, m_wp, m_pe;
    int         m_run, m_err, m_wrap;
    logic [3:0] m_pc;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_locked = 0; m_ep = 0; m_wp = 0; m_pe = 0;
        m_run = 0; m_err = 0; m_wrap = 0; m_pc = '0;
    endfunction

    function automatic void model_step(input bit en, input logic [3:0] c, input bit cl);
        int  expect_v;
        bit  ok;
        m_ep = 0;
        m_wp = 0;
        if (cl) begin
            model_reset();
            return;
        end
        if (!m_valid) begin
            m_valid = 1; m_run = 0; m_locked = 0;
        end else begin
            expect_v = m_pe ? (int'(m_pc) + 1) % 16 : int'(m_pc);
            ok = (int'(c) == expect_v);
            if (m_locked) begin
                if (!ok) begin
                    m_ep = 1; m_err++; m_run = 0; m_locked = 0;
                end else if (m_pe && m_pc == 4'd15) begin
                    m_wp = 1; m_wrap++;
                end
            end else if (!ok) begin
                m_run = 0;
            end else if (m_pe) begin
                m_run++;
                if (m_run >= LC) m_locked = 1;
            end
        end
        m_pc = c;
        m_pe = en;
    endfunction

    // One clock: present the next counter value (or a forced one), clock it, update the model.
    task automatic tick(input bit en, input bit cl, input bit frc, input logic [3:0] fv);
        logic [3:0] nxt;
        nxt = cur_en ? cur_cnt + 4'd1 : cur_cnt;
        if (frc) nxt = fv;
        @(negedge clk);
        cnt_en_s = en;
        count_s  = nxt;
        clr_s    = cl;
        cur_cnt  = nxt;
        cur_en   = en;
        @(posedge clk);
        model_step(en, nxt, cl);
        #1;
    endtask

    function automatic logic [3:0] bad_value();
        logic [3:0] good;
        good = cur_en ? cur_cnt + 4'd1 : cur_cnt;
        return good ^ 4'($urandom_range(1, 15));
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rstb = 1'b0; cnt_en_s = 1'b0; count_s = '0; clr_s = 1'b0;
        cur_cnt = '0; cur_en = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; cnt_en_s = 1'b0; count_s = '0; clr_s = 1'b0;
        cur_cnt = '0; cur_en = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus1.locked !== 1'b0 || bus1.err_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0 ||
            bus1.err_count !== 8'd0 || bus1.wrap_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got locked=%0b ep=%0b wp=%0b err=%0d wrap=%0d required all 0",
                     bus1.locked, bus1.err_pulse, bus1.wrap_pulse, bus1.err_count, bus1.wrap_count);
        end
        rstb = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_lock_latency();
        for (int e = 1; e <= 1 + LC; e++) begin
            tick(1, 0, 0, '0);
            checks++;
            if (bus1.locked !== ((e == 1 + LC) ? 1'b1 : 1'b0) || bus1.locked !== m_locked) begin
                errors++;
                $display("FAIL lock_latency edge %0d got locked=%0b required %0b", e, bus1.locked,
                         (e == 1 + LC));
            end
        end
        checks++;
        if (bus1.err_count !== 8'd0) begin
            errors++;
            $display("FAIL lock_err_count got %0d required 0", bus1.err_count);
        end
        $display("test_lock_latency done locked=%0b", bus1.locked);
    endtask

    task automatic test_hold();
        bit seq [6] = '{1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            tick(seq[i], 0, 0, '0);
            checks++;
            if (bus1.locked !== 1'b1 || bus1.err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL hold step %0d got locked=%0b ep=%0b required locked=1 ep=0",
                         i, bus1.locked, bus1.err_pulse);
            end
        end
        $display("test_hold done count=%0d", cur_cnt);
    endtask

    task automatic test_error();
        int guard = 0;
        while (cur_cnt + 4'd1 != 4'd5 && guard < 20) begin
            tick(1, 0, 0, '0);
            guard++;
        end
        tick(1, 0, 0, '0);
        tick(1, 0, 1, 4'd7);
        checks++;
        if (bus1.err_pulse !== 1'b1 || bus1.err_count !== 8'd1 || bus1.locked !== 1'b0) begin
            errors++;
            $display("FAIL error_detect got ep=%0b err=%0d locked=%0b required ep=1 err=1 locked=0",
                     bus1.err_pulse, bus1.err_count, bus1.locked);
        end
        for (int i = 1; i <= LC; i++) begin
            tick(1, 0, 0, '0);
            checks++;
            if (bus1.err_pulse !== 1'b0 || bus1.locked !== ((i == LC) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL relock step %0d got ep=%0b locked=%0b required ep=0 locked=%0b",
                         i, bus1.err_pulse, bus1.locked, (i == LC));
            end
        end
        $display("test_error done err_count=%0d", bus1.err_count);
    endtask

    task automatic test_wrap();
        int seen = 0;
        int base = m_wrap;
        for (int i = 0; i < 32; i++) begin
            tick(1, 0, 0, '0);
            if (bus1.wrap_pulse === 1'b1) seen++;
        end
        checks++;
        if (seen != 2 || bus1.wrap_count !== 8'(base + 2) || m_wrap != base + 2) begin
            errors++;
            $display("FAIL wrap got pulses=%0d count=%0d required pulses=2 count=%0d",
                     seen, bus1.wrap_count, base + 2);
        end
        $display("test_wrap done wrap_count=%0d", bus1.wrap_count);
    endtask

    task automatic test_err_saturation();
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 1 + LC; i++) tick(1, 0, 0, '0);
        for (int n = 0; n < 5; n++) begin
            tick(1, 0, 1, bad_value());
            if (bus2.err_pulse === 1'b1) pulses++;
            for (int i = 0; i < LC; i++) tick(1, 0, 0, '0);
            checks++;
            if (bus2.locked !== 1'b1 || bus2.err_count !== 2'(sat(n + 1, 3))) begin
                errors++;
                $display("FAIL sat_relock %0d got locked=%0b err=%0d required locked=1 err=%0d",
                         n, bus2.locked, bus2.err_count, sat(n + 1, 3));
            end
        end
        checks++;
        if (pulses != 5 || bus2.err_count !== 2'd3 || bus1.err_count !== 8'd5) begin
            errors++;
            $display("FAIL err_saturate got pulses=%0d sat_err=%0d err=%0d required 5 3 5",
                     pulses, bus2.err_count, bus1.err_count);
        end
        $display("test_err_saturation done pulses=%0d", pulses);
    endtask

    task automatic test_clr();
        apply_reset();
        for (int i = 0; i < 1 + LC; i++) tick(1, 0, 0, '0);
        for (int n = 0; n < 2; n++) begin
            tick(1, 0, 1, bad_value());
            for (int i = 0; i < LC; i++) tick(1, 0, 0, '0);
        end
        checks++;
        if (bus1.err_count !== 8'd2 || bus1.locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup got err=%0d locked=%0b required 2 1", bus1.err_count, bus1.locked);
        end
        // Clear on the same edge as a bad step: clear wins.
        tick(1, 1, 1, bad_value());
        checks++;
        if (bus1.locked !== 1'b0 || bus1.err_count !== 8'd0 || bus1.wrap_count !== 8'd0 ||
            bus1.err_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_apply got locked=%0b err=%0d wrap=%0d ep=%0b wp=%0b required all 0",
                     bus1.locked, bus1.err_count, bus1.wrap_count, bus1.err_pulse, bus1.wrap_pulse);
        end
        for (int e = 1; e <= 1 + LC; e++) begin
            tick(1, 0, 0, '0);
            checks++;
            if (bus1.locked !== ((e == 1 + LC) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL clr_relock edge %0d got locked=%0b required %0b", e, bus1.locked,
                         (e == 1 + LC));
            end
        end
        $display("test_clr done locked=%0b", bus1.locked);
    endtask

    task automatic test_random();
        bit en, cl, frc;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            frc = ($urandom_range(0, 19) == 0);
            cl  = ($urandom_range(0, 99) == 0);
            tick(en, cl, frc, bad_value());
            checks++;
            if (bus1.locked !== m_locked || bus1.err_pulse !== m_ep || bus1.wrap_pulse !== m_wp ||
                bus1.err_count !== 8'(sat(m_err, 255)) || bus1.wrap_count !== 8'(sat(m_wrap, 255)) ||
                bus2.err_count !== 2'(sat(m_err, 3))) begin
                errors++;
                bad++;
                $display("FAIL random cycle %0d got l=%0b ep=%0b wp=%0b e=%0d w=%0d e2=%0d required l=%0b ep=%0b wp=%0b e=%0d w=%0d e2=%0d",
                         i, bus1.locked, bus1.err_pulse, bus1.wrap_pulse, bus1.err_count,
                         bus1.wrap_count, bus2.err_count, m_locked, m_ep, m_wp, sat(m_err, 255),
                         sat(m_wrap, 255), sat(m_err, 3));
            end
        end
        $display("test_random done cycles=400 errs_model=%0d wraps_model=%0d bad=%0d", m_err, m_wrap, bad);
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 1 + LC; i++) tick(1, 0, 0, '0);
        tick(1, 0, 1, bad_value());
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (bus1.locked !== 1'b0 || bus1.err_pulse !== 1'b0 || bus1.wrap_pulse !== 1'b0 ||
            bus1.err_count !== 8'd0 || bus1.wrap_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got locked=%0b ep=%0b wp=%0b err=%0d wrap=%0d required all 0",
                     bus1.locked, bus1.err_pulse, bus1.wrap_pulse, bus1.err_count, bus1.wrap_count);
        end
        cur_cnt = '0; cur_en = 0; cnt_en_s = 1'b0; count_s = '0;
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_hold();
        test_error();
        test_wrap();
        test_err_saturation();
        test_clr();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_seq_monitor.md
# bin_seq_monitor

Downstream checker for the 4-bit enabled binary counter stage. It samples the counter's `count` output and the shared `cnt_en` every clock and verifies that each step is either a correct +1 (mod 2^WIDTH) increment or a correct hold. It acquires lock after a run of correct increments, flags and counts sequence errors while locked, and counts wrap-arounds, giving benches and on-chip debug a single pass/fail view of the counter.

## Interface
- `WIDTH`, default 4, width of the monitored count.
- `LOCK_COUNT`, default 3, number of consecutive correct enabled increments required to lock (≥1).
- `ERR_CNT_W`, default 8, width of the saturating error counter.
- `WRAP_CNT_W`, default 8, width of the saturating wrap counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `cnt_en`  in  1  the same enable that drives the upstream counter.
- `count`  in  WIDTH  upstream counter output.
- `clr`  in  1  synchronous statistics clear and resync.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per detected error while locked.
- `err_count`  out  ERR_CNT_W  saturating count of errors.
- `wrap_pulse`  out  1  one-cycle pulse per wrap seen while locked.
- `wrap_count`  out  WRAP_CNT_W  saturating count of wraps.

## Operation
- Internal registers: `prev_count` (WIDTH), `prev_en` (1), `run` (counts up to LOCK_COUNT), FSM state.
- Every edge: `prev_count <= count`, `prev_en <= cnt_en` (except on reset/clr).
- Expected value at an edge: `exp = prev_en ? prev_count + 1 (mod 2^WIDTH) : prev_count`. Match means `count == exp`.
- Step classification (only when a previous sample is valid): good increment = match and `prev_en`=1; good hold = match and `prev_en`=0; bad = mismatch.
- Wrap = good increment with `prev_count` all-ones and `count` zero.
- FSM:
  - UNSYNC: no valid previous sample. On the next edge, capture the sample and go to ACQUIRE with `run`=0.
  - ACQUIRE: a good increment increments `run`; a good hold leaves `run` unchanged; bad clears `run` to 0. Errors are not counted here. When a good increment makes `run` reach LOCK_COUNT, go to LOCKED.
  - LOCKED: good steps stay. A wrap pulses `wrap_pulse` and increments `wrap_count`. A bad step pulses `err_pulse`, increments `err_count`, clears `run` and goes to ACQUIRE.
- Both counters saturate at all-ones. Pulses still fire when saturated.
- `clr`=1 (synchronous, highest priority after reset): state goes to UNSYNC, `run`, both counters and both pulses go to 0, and `prev_*` is not valid. `cnt_en` and `count` are ignored that edge.
- Reset (`rstb`=0, asynchronous): state goes to UNSYNC. `locked`, `err_pulse`, `wrap_pulse`, `err_count`, `wrap_count`, `run`, `prev_count` and `prev_en` all go to 0.
- Arbitrary upstream RESET_VALUE is supported: lock is never assumed from a particular start value.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- An error is present when `count` at edge k mismatches the value predicted from the samples at edge k-1. `err_pulse` is high for exactly the cycle after edge k, and `err_count` updates at edge k. `locked` drops at edge k.
- Lock latency: with `cnt_en` held high after reset release, the first edge captures the sample (UNSYNC→ACQUIRE). `locked` rises at the LOCK_COUNT-th following edge, i.e. edge 1+LOCK_COUNT after release.
- A wrap and an error cannot coincide: a wrap is by definition a good step.
- `clr` concurrent with an error or wrap: `clr` wins; no pulse, counters read 0.
- Upstream counter reset mid-run (its `count` jumps to its reset value while locked): one error is counted, then the FSM reacquires.

## Test plan
- Reset release, `cnt_en`=1, counter running from 0 (LOCK_COUNT=3) -> `locked`=0 through edge 3, `locked`=1 after edge 4, `err_count`=0.
- Locked; `cnt_en` toggles 1,0,0,1 -> holds accepted, `locked` stays 1, no `err_pulse`.
- Locked; force `count` 5→7 with `cnt_en`=1 -> one `err_pulse`, `err_count`=1, `locked`=0, relock after 3 good increments.
- Locked; counter passes 15→0 twice -> two `wrap_pulse`s, `wrap_count`=2.
- ERR_CNT_W=2; inject 5 errors, each followed by relock -> `err_count` saturates at 3, and 5 pulses are seen.
- `clr` asserted for one cycle while locked with `err_count`=2 -> next cycle `locked`=0, `err_count`=0, `wrap_count`=0, relock after 1+LOCK_COUNT edges. `rstb` low mid-cycle clears all outputs immediately.
